// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: 2*DW-bit dividend by DW-bit divisor,
// one quotient bit per clock, results registered on entry to DONE.
module seq_restoring_divider #(
  parameter int DW = 4,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [2*DW-1:0] q_r;
  logic [DW-1:0]   d_r;
  // The partial remainder is always below the divisor, so its extra top bit
  // is never set between iterations and is not stored.
  logic [DW-1:0]   rem_r;

  logic [DW:0]     t_s;
  logic            ge_s;
  logic [DW-1:0]   r_next_s;
  logic [2*DW-1:0] q_next_s;
  logic            last_s;

  // One restoring iteration: trial subtract of the divisor from the shifted remainder.
  always_comb begin
    t_s      = {rem_r, q_r[2*DW-1]};
    ge_s     = (t_s >= {1'b0, d_r});
    if (ge_s) begin
      r_next_s = t_s[DW-1:0] - d_r;
    end else begin
      r_next_s = t_s[DW-1:0];
    end
    q_next_s = {q_r[2*DW-2:0], ge_s};
    last_s   = (cnt_r == CW'(2*DW-1));
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      q_r         <= {(2*DW){1'b0}};
      d_r         <= {DW{1'b0}};
      rem_r       <= {DW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {(2*DW){1'b0}};
      remainder   <= {DW{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            q_r         <= dividend;
            d_r         <= divisor;
            rem_r       <= {DW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            div_by_zero <= 1'b0;
            if (divisor != {DW{1'b0}}) begin
              state_r <= RUN;
              busy    <= 1'b1;
            end else begin
              state_r     <= DONE;
              done        <= 1'b1;
              quotient    <= {(2*DW){1'b1}};
              remainder   <= {DW{1'b0}};
              div_by_zero <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          q_r   <= q_next_s;
          rem_r <= r_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            state_r   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next_s;
            remainder <= r_next_s;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (DW=4): directed cases,
// handshake/reset corners, exhaustive and random runs against a / and % model.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int vectors;
  int miscompares;

  seq_restoring_divider #(.DW(4), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 4'($urandom);
  endtask

  // Waits (bounded) for done and compares against the arithmetic model.
  task automatic await_result(input logic [7:0] a, input logic [3:0] b, input int pre,
                              input string tag);
    int cycles;
    int bcnt;
    int both;
    int exp_q;
    int exp_r;
    cycles = pre;
    bcnt = 0;
    both = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (busy === 1'b1) bcnt++;
      if (busy === 1'b1 && done === 1'b1) both++;
    end while (done !== 1'b1 && cycles < 40);
    exp_q = (b == 4'd0) ? 255 : int'(a) / int'(b);
    exp_r = (b == 4'd0) ? 0 : int'(a) % int'(b);
    chk({tag, "_latency"}, cycles, (b == 4'd0) ? 1 : 9);
    if (pre == 0) chk({tag, "_busy_cycles"}, bcnt, (b == 4'd0) ? 0 : 8);
    chk({tag, "_busy_and_done"}, both, 0);
    chk({tag, "_quotient"}, quotient, exp_q);
    chk({tag, "_remainder"}, remainder, exp_r);
    chk({tag, "_div_by_zero"}, div_by_zero, (b == 4'd0) ? 1 : 0);
  endtask

  initial begin
    int done_seen;
    logic [7:0] a;
    logic [3:0] b;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 4'd0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Typical case, one-cycle done pulse, holding through IDLE
    issue(8'd200, 4'd7);
    await_result(8'd200, 4'd7, 0, "typ_200_7");
    @(negedge clk);
    chk("typ_done_pulse", done, 0);
    @(negedge clk);
    @(negedge clk);
    chk("typ_hold_q", quotient, 28);
    chk("typ_hold_r", remainder, 4);

    // Bounds
    issue(8'd255, 4'd1);  await_result(8'd255, 4'd1, 0, "b_255_1");
    @(negedge clk);
    issue(8'd255, 4'd15); await_result(8'd255, 4'd15, 0, "b_255_15");
    @(negedge clk);
    issue(8'd0, 4'd15);   await_result(8'd0, 4'd15, 0, "b_0_15");
    @(negedge clk);
    issue(8'd14, 4'd15);  await_result(8'd14, 4'd15, 0, "b_14_15");
    @(negedge clk);

    // Divide by zero, then a normal run clears the flag at start and keeps old quotient
    issue(8'd93, 4'd0);   await_result(8'd93, 4'd0, 0, "dz_93_0");
    @(negedge clk);
    issue(8'd93, 4'd3);
    chk("dz_clear_at_start", div_by_zero, 0);
    chk("dz_q_held_at_start", quotient, 255);
    await_result(8'd93, 4'd3, 0, "dz_93_3");
    @(negedge clk);

    // start re-pulsed during RUN is ignored
    issue(8'd200, 4'd7);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 4'd9;
    @(negedge clk);
    start = 1'b0;
    await_result(8'd200, 4'd7, 3, "ign_200_7");
    // start held in the DONE cycle: back-to-back with no IDLE gap
    issue(8'd100, 4'd9);
    chk("b2b_busy_now", busy, 1);
    await_result(8'd100, 4'd9, 0, "b2b_100_9");
    @(negedge clk);

    // Asynchronous reset mid-run
    issue(8'd200, 4'd7);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_quotient", quotient, 0);
    chk("mid_rst_remainder", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("mid_rst_no_done", done_seen, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd60, 4'd6);   await_result(8'd60, 4'd6, 0, "post_rst_60_6");
    @(negedge clk);

    // Exhaustive non-zero divisors, back-to-back, with invariant checks
    issue(8'd0, 4'd1);
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        a = 8'(ai);
        b = 4'(bi);
        await_result(a, b, 0, "exh");
        chk("exh_invariant", int'(quotient) * int'(b) + int'(remainder), int'(a));
        chk("exh_rem_lt_div", (remainder < b) ? 1 : 0, 1);
        if (bi < 15) issue(a, 4'(bi + 1));
        else if (ai < 255) issue(8'(ai + 1), 4'd1);
        else @(negedge clk);
      end
    end

    // Products of 4x4 multiplications undone by the b operand
    for (int k = 0; k < 20; k++) begin
      a = 8'($urandom_range(0, 15));
      b = 4'($urandom_range(1, 15));
      issue(8'(a * b), b);
      await_result(8'(a * b), b, 0, "mul_inv");
      chk("mul_inv_a", quotient, a);
      chk("mul_inv_rem0", remainder, 0);
      @(negedge clk);
    end

    // Random operands including zero divisors
    for (int k = 0; k < 60; k++) begin
      a = 8'($urandom);
      b = 4'($urandom_range(0, 15));
      issue(a, b);
      await_result(a, b, 0, "rnd");
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
